sprite_motion_ctrl: RTL and testbench

- Owns the positions of the two overlay sprites drawn over the background image by the VGA pipeline.
- Decodes the PS/2 receiver's scan-code stream (make/break/extended) into a held-key vector.
- Applies one motion step per frame, on the rising edge of the timing generator's screen-end strobe.
- Clamps the shared motion so both sprites stay fully on screen and keep their relative offset.
- Replaces ad-hoc per-code position nudging; gives the overlay address logic stable per-frame coordinates.

---
 rtl/strum_vga_pkg.sv | 44 ++++
 rtl/ps2_key_tracker.sv | 64 ++++++
 rtl/sprite_motion_ctrl.sv | 157 +++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strum_vga_pkg.sv
// Shared constants for the VGA overlay: screen geometry, PS/2 scan codes,
// decoder state encoding and key_state bit positions.
package strum_vga_pkg;

    localparam int DEF_SCREEN_W    = 640;
    localparam int DEF_SCREEN_H    = 480;
    localparam int DEF_SPRITE_SIZE = 51;
    localparam int DEF_STEP        = 4;
    localparam int POS_W           = 10;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam int KEY_UP    = 0;
    localparam int KEY_DOWN  = 1;
    localparam int KEY_LEFT  = 2;
    localparam int KEY_RIGHT = 3;

    typedef enum logic [1:0] {
        DEC_IDLE      = 2'd0,
        DEC_BREAK     = 2'd1,
        DEC_EXT       = 2'd2,
        DEC_EXT_BREAK = 2'd3
    } dec_state_t;

    // One-hot key_state bit for a mapped scan code, zero for anything else.
    function automatic logic [3:0] key_onehot(input logic [7:0] code);
        logic [3:0] hit;
        hit = 4'b0000;
        case (code)
            KEY_W:   hit[KEY_UP]    = 1'b1;
            KEY_S:   hit[KEY_DOWN]  = 1'b1;
            KEY_A:   hit[KEY_LEFT]  = 1'b1;
            KEY_D:   hit[KEY_RIGHT] = 1'b1;
            default: hit = 4'b0000;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_tracker.sv
// PS/2 make/break/extended decoder producing the held-key vector {right,left,down,up}.
//
// state         | meaning
// DEC_IDLE      | waiting for a make code or a prefix byte
// DEC_BREAK     | F0 seen; next byte releases a mapped key
// DEC_EXT       | E0 seen; extended key, never touches key_state
// DEC_EXT_BREAK | E0 F0 seen; next byte is swallowed
module ps2_key_tracker
    import strum_vga_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_done_tick,
    input  logic [7:0] scan_data,
    output logic [3:0] key_state
);

    dec_state_t state_q, state_d;
    logic [3:0] keys_q, keys_d;
    logic [3:0] hit;

    assign hit = key_onehot(scan_data);

    always_comb begin
        state_d = state_q;
        keys_d  = keys_q;
        if (scan_done_tick) begin
            case (state_q)
                DEC_IDLE: begin
                    if (scan_data == PS2_BREAK) begin
                        state_d = DEC_BREAK;
                    end else if (scan_data == PS2_EXT) begin
                        state_d = DEC_EXT;
                    end else begin
                        keys_d = keys_q | hit;
                    end
                end
                DEC_BREAK: begin
                    keys_d  = keys_q & ~hit;
                    state_d = DEC_IDLE;
                end
                DEC_EXT: begin
                    state_d = (scan_data == PS2_BREAK) ? DEC_EXT_BREAK : DEC_IDLE;
                end
                default: begin
                    state_d = DEC_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DEC_IDLE;
            keys_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            keys_q  <= keys_d;
        end
    end

    assign key_state = keys_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame motion of the two overlay sprites from held PS/2 keys.
// Build option POS_WRAP_EN: sprites wrap around the screen edges instead of clamping.
module sprite_motion_ctrl
    import strum_vga_pkg::*;
#(
    parameter int SCREEN_W    = DEF_SCREEN_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int SPRITE_SIZE = DEF_SPRITE_SIZE,
    parameter int STEP        = DEF_STEP,
    parameter int INIT0_X     = 0,
    parameter int INIT0_Y     = 0,
    parameter int INIT1_X     = 100,
    parameter int INIT1_Y     = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_done_tick,
    input  logic [7:0]       scan_data,
    input  logic             screen_end,
    output logic [POS_W-1:0] sprite0_x,
    output logic [POS_W-1:0] sprite0_y,
    output logic [POS_W-1:0] sprite1_x,
    output logic [POS_W-1:0] sprite1_y,
    output logic [3:0]       key_state,
    output logic             move_pulse
);

    localparam logic signed [10:0] MAX_X_S = 11'(SCREEN_W - SPRITE_SIZE);
    localparam logic signed [10:0] MAX_Y_S = 11'(SCREEN_H - SPRITE_SIZE);
    localparam logic signed [10:0] STEP_S  = 11'(STEP);

    logic             screen_end_q;
    logic             tick;
    logic [POS_W-1:0] s0x_q, s0x_d, s0y_q, s0y_d;
    logic [POS_W-1:0] s1x_q, s1x_d, s1y_q, s1y_d;
    logic             move_q, move_d;

    ps2_key_tracker u_key_tracker (
        .clk            (clk),
        .reset          (reset),
        .scan_done_tick (scan_done_tick),
        .scan_data      (scan_data),
        .key_state      (key_state)
    );

    function automatic logic signed [10:0] to_s(input logic [POS_W-1:0] p);
        return $signed({1'b0, p});
    endfunction

    assign tick = screen_end & ~screen_end_q;

`ifdef POS_WRAP_EN
    // Each coordinate moves a full step on its own and re-enters from the far edge.
    function automatic logic signed [10:0] wrap_step(input logic inc, input logic dec,
                                                     input logic signed [10:0] p,
                                                     input logic signed [10:0] max_v);
        logic signed [10:0] n;
        n = p;
        if (inc && !dec) begin
            n = p + STEP_S;
        end else if (dec && !inc) begin
            n = p - STEP_S;
        end
        if (n < 11'sd0) begin
            n = n + max_v + 11'sd1;
        end else if (n > max_v) begin
            n = n - max_v - 11'sd1;
        end
        return n;
    endfunction

    logic x_active, y_active;

    assign x_active = key_state[KEY_RIGHT] ^ key_state[KEY_LEFT];
    assign y_active = key_state[KEY_DOWN]  ^ key_state[KEY_UP];

    always_comb begin
        s0x_d  = s0x_q;
        s0y_d  = s0y_q;
        s1x_d  = s1x_q;
        s1y_d  = s1y_q;
        move_d = 1'b0;
        if (tick) begin
            s0x_d  = 10'(wrap_step(key_state[KEY_RIGHT], key_state[KEY_LEFT], to_s(s0x_q), MAX_X_S));
            s1x_d  = 10'(wrap_step(key_state[KEY_RIGHT], key_state[KEY_LEFT], to_s(s1x_q), MAX_X_S));
            s0y_d  = 10'(wrap_step(key_state[KEY_DOWN],  key_state[KEY_UP],   to_s(s0y_q), MAX_Y_S));
            s1y_d  = 10'(wrap_step(key_state[KEY_DOWN],  key_state[KEY_UP],   to_s(s1y_q), MAX_Y_S));
            move_d = x_active | y_active;
        end
    end
`else
    // One delta per axis, limited by whichever sprite is closest to the edge it heads for.
    function automatic logic signed [10:0] clamp_delta(input logic inc, input logic dec,
                                                       input logic signed [10:0] p0,
                                                       input logic signed [10:0] p1,
                                                       input logic signed [10:0] max_v);
        logic signed [10:0] lo, hi, room, d;
        lo = (p0 < p1) ? p0 : p1;
        hi = (p0 > p1) ? p0 : p1;
        room = max_v - hi;
        d = 11'sd0;
        if (inc && !dec) begin
            d = (room < STEP_S) ? room : STEP_S;
        end else if (dec && !inc) begin
            d = (lo < STEP_S) ? -lo : -STEP_S;
        end
        return d;
    endfunction

    logic signed [10:0] dx, dy;

    assign dx = clamp_delta(key_state[KEY_RIGHT], key_state[KEY_LEFT],
                            to_s(s0x_q), to_s(s1x_q), MAX_X_S);
    assign dy = clamp_delta(key_state[KEY_DOWN], key_state[KEY_UP],
                            to_s(s0y_q), to_s(s1y_q), MAX_Y_S);

    always_comb begin
        s0x_d  = s0x_q;
        s0y_d  = s0y_q;
        s1x_d  = s1x_q;
        s1y_d  = s1y_q;
        move_d = 1'b0;
        if (tick) begin
            s0x_d  = 10'(to_s(s0x_q) + dx);
            s1x_d  = 10'(to_s(s1x_q) + dx);
            s0y_d  = 10'(to_s(s0y_q) + dy);
            s1y_d  = 10'(to_s(s1y_q) + dy);
            move_d = (dx != 11'sd0) || (dy != 11'sd0);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            screen_end_q <= 1'b0;
            s0x_q        <= 10'(INIT0_X);
            s0y_q        <= 10'(INIT0_Y);
            s1x_q        <= 10'(INIT1_X);
            s1y_q        <= 10'(INIT1_Y);
            move_q       <= 1'b0;
        end else begin
            screen_end_q <= screen_end;
            s0x_q        <= s0x_d;
            s0y_q        <= s0y_d;
            s1x_q        <= s1x_d;
            s1y_q        <= s1y_d;
            move_q       <= move_d;
        end
    end

    assign sprite0_x  = s0x_q;
    assign sprite0_y  = s0y_q;
    assign sprite1_x  = s1x_q;
    assign sprite1_y  = s1y_q;
    assign move_pulse = move_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: two instances (default and sprite 1 near the right edge)
// checked every cycle against a behavioural model, plus literal expectations.
module tb_sprite_motion_ctrl;

    localparam int MAXX  = 640 - 51;
    localparam int MAXY  = 480 - 51;
    localparam int STEPM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scan_done_tick = 1'b0;
    logic [7:0] scan_data = 8'h00;
    logic       screen_end = 1'b0;

    logic [9:0] a_x0, a_y0, a_x1, a_y1, b_x0, b_y0, b_x1, b_y1;
    logic [3:0] a_keys, b_keys;
    logic       a_pulse, b_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    bit checking = 1'b0;
    int pcnt_a = 0;
    int pcnt_b = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl u_dut_a (
        .clk(clk), .reset(reset), .scan_done_tick(scan_done_tick), .scan_data(scan_data),
        .screen_end(screen_end), .sprite0_x(a_x0), .sprite0_y(a_y0), .sprite1_x(a_x1),
        .sprite1_y(a_y1), .key_state(a_keys), .move_pulse(a_pulse)
    );

    sprite_motion_ctrl #(.INIT1_X(588)) u_dut_b (
        .clk(clk), .reset(reset), .scan_done_tick(scan_done_tick), .scan_data(scan_data),
        .screen_end(screen_end), .sprite0_x(b_x0), .sprite0_y(b_y0), .sprite1_x(b_x1),
        .sprite1_y(b_y1), .key_state(b_keys), .move_pulse(b_pulse)
    );

    // ---------------- behavioural model ----------------
    // mpos[inst] = {x0, y0, x1, y1}
    int  mpos[2][4];
    int  minit[2][4] = '{'{0, 0, 100, 100}, '{0, 0, 588, 100}};
    bit  [3:0] mkeys;
    bit  mbrk, mext, mprev;
    bit  mpulse[2];

    function automatic int dir_of(bit pos, bit neg);
        if (pos && !neg) return 1;
        if (neg && !pos) return -1;
        return 0;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int code_bit(logic [7:0] b);
        case (b)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) mpos[k][j] = minit[k][j];
            mpulse[k] = 1'b0;
        end
        mkeys = 4'b0; mbrk = 1'b0; mext = 1'b0; mprev = 1'b0;
    endtask

    task automatic model_frame();
        int dir[2];
        int lim[2];
        dir[0] = dir_of(mkeys[3], mkeys[2]);
        dir[1] = dir_of(mkeys[1], mkeys[0]);
        lim[0] = MAXX;
        lim[1] = MAXY;
        for (int k = 0; k < 2; k++) begin
            bit moved;
            moved = 1'b0;
            for (int ax = 0; ax < 2; ax++) begin
`ifdef POS_WRAP_EN
                for (int s = 0; s < 2; s++) begin
                    int p;
                    p = mpos[k][ax + 2*s] + dir[ax] * STEPM;
                    if (p < 0) p += lim[ax] + 1;
                    else if (p > lim[ax]) p -= lim[ax] + 1;
                    mpos[k][ax + 2*s] = p;
                end
                if (dir[ax] != 0) moved = 1'b1;
`else
                int d;
                int p0;
                int p1;
                p0 = mpos[k][ax];
                p1 = mpos[k][ax + 2];
                d = 0;
                if (dir[ax] < 0) d = -imin(STEPM, imin(p0, p1));
                if (dir[ax] > 0) d = imin(STEPM, lim[ax] - imax(p0, p1));
                mpos[k][ax]     = p0 + d;
                mpos[k][ax + 2] = p1 + d;
                if (d != 0) moved = 1'b1;
`endif
            end
            mpulse[k] = moved;
        end
    endtask

    task automatic model_byte(logic [7:0] b);
        int kb;
        kb = code_bit(b);
        if (mbrk) begin
            if (!mext && kb >= 0) mkeys[kb] = 1'b0;
            mbrk = 1'b0;
            mext = 1'b0;
        end else if (mext) begin
            if (b == 8'hF0) mbrk = 1'b1;
            else mext = 1'b0;
        end else if (b == 8'hF0) begin
            mbrk = 1'b1;
        end else if (b == 8'hE0) begin
            mext = 1'b1;
        end else if (kb >= 0) begin
            mkeys[kb] = 1'b1;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            if (screen_end && !mprev) model_frame();
            else begin
                mpulse[0] = 1'b0;
                mpulse[1] = 1'b0;
            end
            mprev = screen_end;
            if (scan_done_tick) model_byte(scan_data);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (a_pulse) pcnt_a++;
        if (b_pulse) pcnt_b++;
        if (checking) begin
            chk("a.sprite0_x", a_x0, mpos[0][0]);
            chk("a.sprite0_y", a_y0, mpos[0][1]);
            chk("a.sprite1_x", a_x1, mpos[0][2]);
            chk("a.sprite1_y", a_y1, mpos[0][3]);
            chk("a.key_state", a_keys, mkeys);
            chk("a.move_pulse", a_pulse, mpulse[0]);
            chk("b.sprite0_x", b_x0, mpos[1][0]);
            chk("b.sprite0_y", b_y0, mpos[1][1]);
            chk("b.sprite1_x", b_x1, mpos[1][2]);
            chk("b.sprite1_y", b_y1, mpos[1][3]);
            chk("b.key_state", b_keys, mkeys);
            chk("b.move_pulse", b_pulse, mpulse[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send_byte(logic [7:0] b);
        @(posedge clk); #1;
        scan_data = b;
        scan_done_tick = 1'b1;
        @(posedge clk); #1;
        scan_done_tick = 1'b0;
    endtask

    task automatic frame();
        @(posedge clk); #1;
        screen_end = 1'b1;
        @(posedge clk); #1;
        screen_end = 1'b0;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    logic [7:0] byte_tab[9] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hF0, 8'hF0, 8'hF0, 8'hE0, 8'h5A};

    initial begin
        int base_a;
        int base_b;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checking = 1'b1;

        // reset mid-frame with a key held
        send_byte(8'h23);
        @(posedge clk); #1 screen_end = 1'b1;
        do_reset();
        @(negedge clk);
        chk("rst.sprite0_x", a_x0, 0);
        chk("rst.sprite0_y", a_y0, 0);
        chk("rst.sprite1_x", a_x1, 100);
        chk("rst.sprite1_y", a_y1, 100);
        chk("rst.key_state", a_keys, 0);
        chk("rst.move_pulse", a_pulse, 0);
        screen_end = 1'b0;

        // hold D for three frames, then release
        do_reset();
        base_a = pcnt_a;
        send_byte(8'h23);
        repeat (3) frame();
        @(negedge clk);
        chk("d3.sprite0_x", a_x0, 12);
        chk("d3.sprite1_x", a_x1, 112);
        chk("d3.sprite0_y", a_y0, 0);
        chk("d3.sprite1_y", a_y1, 100);
        chk("d3.pulses", pcnt_a - base_a, 3);
        send_byte(8'hF0);
        send_byte(8'h23);
        frame();
        @(negedge clk);
        chk("rel.key_state", a_keys, 0);
        chk("rel.sprite0_x", a_x0, 12);
        chk("rel.pulses", pcnt_a - base_a, 3);

        // left at the left edge
        do_reset();
        base_a = pcnt_a;
        send_byte(8'h1C);
        frame();
        @(negedge clk);
`ifdef POS_WRAP_EN
        chk("left.sprite0_x", a_x0, 586);
        chk("left.sprite1_x", a_x1, 96);
        chk("left.pulses", pcnt_a - base_a, 1);
`else
        chk("left.sprite0_x", a_x0, 0);
        chk("left.sprite1_x", a_x1, 100);
        chk("left.pulses", pcnt_a - base_a, 0);
`endif

        // right with sprite 1 one pixel from the right limit
        do_reset();
        send_byte(8'h23);
        frame();
        @(negedge clk);
`ifdef POS_WRAP_EN
        chk("edge1.sprite1_x", b_x1, 2);
        chk("edge1.sprite0_x", b_x0, 4);
`else
        chk("edge1.sprite1_x", b_x1, 589);
        chk("edge1.sprite0_x", b_x0, 1);
`endif
        base_b = pcnt_b;
        frame();
        @(negedge clk);
`ifdef POS_WRAP_EN
        chk("edge2.sprite1_x", b_x1, 6);
        chk("edge2.sprite0_x", b_x0, 8);
        chk("edge2.pulses", pcnt_b - base_b, 1);
`else
        chk("edge2.sprite1_x", b_x1, 589);
        chk("edge2.sprite0_x", b_x0, 1);
        chk("edge2.pulses", pcnt_b - base_b, 0);
`endif

        // opposing keys cancel
        do_reset();
        base_a = pcnt_a;
        send_byte(8'h1D);
        send_byte(8'h1B);
        frame();
        @(negedge clk);
        chk("cancel.key_state", a_keys, 4'b0011);
        chk("cancel.sprite0_y", a_y0, 0);
        chk("cancel.sprite1_y", a_y1, 100);
        chk("cancel.pulses", pcnt_a - base_a, 0);

        // extended codes never touch key_state
        do_reset();
        send_byte(8'hE0);
        send_byte(8'h1D);
        @(negedge clk);
        chk("ext.key_state", a_keys, 0);
        send_byte(8'h23);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h23);
        @(negedge clk);
        chk("extbrk.key_state", a_keys, 4'b1000);
        frame();
        @(negedge clk);
        chk("extbrk.sprite0_x", a_x0, 4);
        chk("extbrk.sprite1_x", a_x1, 104);

        // byte and tick in the same cycle: motion uses the old key_state
        do_reset();
        base_a = pcnt_a;
        @(posedge clk); #1;
        scan_data = 8'h23;
        scan_done_tick = 1'b1;
        screen_end = 1'b1;
        @(posedge clk); #1;
        scan_done_tick = 1'b0;
        screen_end = 1'b0;
        @(negedge clk);
        chk("same.key_state", a_keys, 4'b1000);
        chk("same.sprite0_x", a_x0, 0);
        chk("same.move_pulse", a_pulse, 0);
        frame();
        @(negedge clk);
        chk("same2.sprite0_x", a_x0, 4);

        // long hold to the right limit
        do_reset();
        send_byte(8'h23);
        repeat (160) frame();
        @(negedge clk);
`ifdef POS_WRAP_EN
        chk("far.sprite0_x", a_x0, 50);
        chk("far.sprite1_x", a_x1, 150);
`else
        chk("far.sprite0_x", a_x0, 489);
        chk("far.sprite1_x", a_x1, 589);
`endif

        // randomized traffic, checked by the per-cycle compare
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            scan_done_tick = ($urandom_range(0, 4) == 0);
            scan_data = byte_tab[$urandom_range(0, 8)];
            if ($urandom_range(0, 2) == 0) screen_end = ~screen_end;
            reset = ($urandom_range(0, 1499) == 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        scan_done_tick = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
